// File: rtl/cat_golden_scoreboard.sv
// Golden model and scoreboard for the cat recognizer.
// It snoops APB writes and keeps its own copy of the pixel and weight memories.
// On START it computes the multi-channel dot product, one word per cycle.
// It then waits for the DUT's dut_done and compares CAT with its own verdict.
// Mismatches and timeouts are counted, and APB protocol slips are flagged.
//
// state | meaning
// IDLE  | waiting for a START write to CTRL
// CALC  | accumulating one pixel/weight word per cycle
// WAIT  | golden result ready, waiting for dut_done or timeout
module cat_golden_scoreboard #(
   parameter int Amba_Word        = 24,
   parameter int Amba_Addr_Depth  = 13,
   parameter int Weight_precision = 5,
   parameter int Num_Channels     = 3,
   parameter int Image_Words      = 1024,
   parameter int Timeout_Cycles   = 65535,
   localparam int LW    = Amba_Word / Num_Channels,
   localparam int ACC_W = LW + Weight_precision + $clog2(Image_Words * Num_Channels) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [Amba_Addr_Depth-1:0] PADDR,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [Amba_Word-1:0]       PWDATA,
   input  logic                       CAT,
   input  logic                       dut_done,
   output logic                       busy,
   output logic signed [ACC_W-1:0]    golden_acc,
   output logic                       golden_cat,
   output logic                       golden_valid,
   output logic                       mismatch,
   output logic                       timeout,
   output logic                       proto_err,
   output logic                       write_hazard,
   output logic [15:0]                error_count
);

   localparam int IDX_W = (Image_Words > 1) ? $clog2(Image_Words) : 1;
   localparam int TO_W  = $clog2(Timeout_Cycles + 1);
   localparam int WB    = 2 ** (Amba_Addr_Depth - 1);
   localparam int WP_W  = Num_Channels * Weight_precision;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Image_Words - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(Timeout_Cycles);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic signed [ACC_W-1:0]  acc;
   logic                     mode;
   logic [TO_W-1:0]          to_cnt;

   // Only the weight bits of each lane are kept; the upper lane bits never matter.
   logic [Amba_Word-1:0]     pix_mem [Image_Words];
   logic [WP_W-1:0]          wgt_mem [Image_Words];

   logic                       prev_psel;
   logic                       prev_penable;
   logic                       prev_pwrite;
   logic [Amba_Addr_Depth-1:0] prev_paddr;
   logic [Amba_Word-1:0]       prev_pwdata;

   int                      addr_i;
   logic                    wr_en;
   logic                    pix_hit;
   logic                    wgt_hit;
   logic                    start_wr;
   logic                    mem_wr;
   logic [IDX_W-1:0]        pix_widx;
   logic [IDX_W-1:0]        wgt_widx;
   logic [WP_W-1:0]         wgt_pack;
   logic [Amba_Word-1:0]    pix_word;
   logic [WP_W-1:0]         wgt_word;
   logic signed [ACC_W-1:0] pix_ext;
   logic signed [ACC_W-1:0] wgt_ext;
   logic signed [ACC_W-1:0] word_sum;
   logic signed [ACC_W-1:0] acc_next;
   logic                    cat_next;
   logic                    apb_err;
   logic                    err_evt;

   assign busy   = (state != ST_IDLE);
   assign addr_i = int'(PADDR);

   // Address decode of the snooped write and packing of weight lanes
   always_comb begin
      wr_en    = PSEL & PENABLE & PWRITE;
      pix_hit  = (addr_i >= 1) && (addr_i <= Image_Words);
      wgt_hit  = (addr_i >= WB) && (addr_i < WB + Image_Words);
      start_wr = wr_en && (addr_i == 0) && PWDATA[0];
      mem_wr   = wr_en && (pix_hit || wgt_hit);
      pix_widx = IDX_W'(addr_i - 1);
      wgt_widx = IDX_W'(addr_i - WB);
      wgt_pack = '0;
      for (int c = 0; c < Num_Channels; c++) begin
         wgt_pack[c*Weight_precision +: Weight_precision] = PWDATA[c*LW +: Weight_precision];
      end
   end

   // Shadow memories follow every accepted write, whatever the FSM is doing
   always_ff @(posedge clk) begin
      if (wr_en && pix_hit) pix_mem[pix_widx] <= PWDATA;
      if (wr_en && wgt_hit) wgt_mem[wgt_widx] <= wgt_pack;
   end

   // Dot product of the current word: unsigned pixel lanes times signed weight lanes
   always_comb begin
      pix_word = pix_mem[idx];
      wgt_word = wgt_mem[idx];
      pix_ext  = '0;
      wgt_ext  = '0;
      word_sum = '0;
      for (int c = 0; c < Num_Channels; c++) begin
         pix_ext  = $signed({{(ACC_W-LW){1'b0}}, pix_word[c*LW +: LW]});
         wgt_ext  = $signed({{(ACC_W-Weight_precision){wgt_word[c*Weight_precision+Weight_precision-1]}},
                             wgt_word[c*Weight_precision +: Weight_precision]});
         word_sum = word_sum + pix_ext * wgt_ext;
      end
      acc_next = acc + word_sum;
      cat_next = mode ? !acc_next[ACC_W-1] : (!acc_next[ACC_W-1] && (acc_next != '0));
   end

   // APB violations: enable with no preceding setup, or access-phase signals moving
   always_comb begin
      apb_err = (PENABLE && !prev_penable && !prev_psel) ||
                (PSEL && PENABLE && prev_psel &&
                 ((PADDR != prev_paddr) || (PWRITE != prev_pwrite) || (PWDATA != prev_pwdata)));
      err_evt = (state == ST_WAIT) &&
                ((dut_done && (CAT != golden_cat)) || (!dut_done && (to_cnt == TO_LIMIT)));
   end

   // Previous-cycle copy of the bus for the protocol check
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_psel    <= 1'b0;
         prev_penable <= 1'b0;
         prev_pwrite  <= 1'b0;
         prev_paddr   <= '0;
         prev_pwdata  <= '0;
      end else begin
         prev_psel    <= PSEL;
         prev_penable <= PENABLE;
         prev_pwrite  <= PWRITE;
         prev_paddr   <= PADDR;
         prev_pwdata  <= PWDATA;
      end
   end

   // Main FSM with registered result and pulse outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         acc          <= '0;
         mode         <= 1'b0;
         to_cnt       <= '0;
         golden_acc   <= '0;
         golden_cat   <= 1'b0;
         golden_valid <= 1'b0;
         mismatch     <= 1'b0;
         timeout      <= 1'b0;
         proto_err    <= 1'b0;
         write_hazard <= 1'b0;
      end else begin
         golden_valid <= 1'b0;
         mismatch     <= 1'b0;
         timeout      <= 1'b0;
         proto_err    <= apb_err || (start_wr && busy) || (dut_done && (state == ST_CALC));
         write_hazard <= mem_wr && busy;
         case (state)
            ST_IDLE: begin
               if (start_wr) begin
                  mode  <= PWDATA[1];
                  acc   <= '0;
                  idx   <= '0;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc <= acc_next;
               idx <= idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  golden_acc   <= acc_next;
                  golden_cat   <= cat_next;
                  golden_valid <= 1'b1;
                  to_cnt       <= '0;
                  state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dut_done) begin
                  mismatch <= (CAT != golden_cat);
                  state    <= ST_IDLE;
               end else if (to_cnt == TO_LIMIT) begin
                  timeout <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Saturating count of mismatch and timeout events
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         error_count <= '0;
      end else if (err_evt && (error_count != 16'hFFFF)) begin
         error_count <= error_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_cat_golden_scoreboard.sv
// Self-checking bench for cat_golden_scoreboard.
// A plain-arithmetic model of the image memories predicts sums and verdicts.
module tb_cat_golden_scoreboard;

   localparam int AW    = 13;
   localparam int DW    = 24;
   localparam int NW    = 1024;
   localparam int TO    = 300;
   localparam int ACC_W = 26;
   localparam int WBASE = 4096;

   logic              clk = 1'b0;
   logic              rst;
   logic [AW-1:0]     PADDR;
   logic              PSEL, PENABLE, PWRITE;
   logic [DW-1:0]     PWDATA;
   logic              CAT, dut_done;
   logic              busy;
   logic signed [ACC_W-1:0] golden_acc;
   logic              golden_cat, golden_valid, mismatch, timeout, proto_err, write_hazard;
   logic [15:0]       error_count;

   always #5 clk = ~clk;

   cat_golden_scoreboard #(.Timeout_Cycles(TO)) dut (
      .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .CAT(CAT), .dut_done(dut_done),
      .busy(busy), .golden_acc(golden_acc), .golden_cat(golden_cat),
      .golden_valid(golden_valid), .mismatch(mismatch), .timeout(timeout),
      .proto_err(proto_err), .write_hazard(write_hazard), .error_count(error_count)
   );

   int     checks = 0;
   int     errors = 0;
   int     n_proto = 0, n_haz = 0, n_to = 0, n_mm = 0, n_valid = 0;
   longint exp_err = 0;
   bit [DW-1:0] m_pix [NW];
   bit [DW-1:0] m_wgt [NW];

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (proto_err === 1'b1)    n_proto++;
      if (write_hazard === 1'b1) n_haz++;
      if (timeout === 1'b1)      n_to++;
      if (mismatch === 1'b1)     n_mm++;
      if (golden_valid === 1'b1) n_valid++;
   end

   function automatic longint model_acc();
      longint s = 0;
      for (int i = 0; i < NW; i++) begin
         for (int c = 0; c < 3; c++) begin
            int p, w;
            p = int'((m_pix[i] >> (8*c)) & 24'hFF);
            w = int'((m_wgt[i] >> (8*c)) & 24'h1F);
            if (w >= 16) w = w - 32;
            s += longint'(p * w);
         end
      end
      return s;
   endfunction

   function automatic bit model_cat(input longint s, input bit md);
      return md ? (s >= 0) : (s > 0);
   endfunction

   task automatic apb_wr(input int a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(a); PWDATA = d;
      @(posedge clk); #1;
      PENABLE = 1'b1;
   endtask

   task automatic apb_idle();
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic wr_pix(input int i, input logic [DW-1:0] d);
      m_pix[i] = d;
      apb_wr(1 + i, d);
   endtask

   task automatic wr_wgt(input int i, input logic [DW-1:0] d);
      m_wgt[i] = d;
      apb_wr(WBASE + i, d);
   endtask

   task automatic fill(input bit do_pix, input bit do_wgt, input bit rnd,
                       input logic [DW-1:0] pd, input logic [DW-1:0] wd);
      for (int i = 0; i < NW; i++) begin
         if (do_pix) wr_pix(i, rnd ? DW'($urandom) : pd);
         if (do_wgt) wr_wgt(i, rnd ? DW'($urandom) : wd);
      end
      apb_idle();
   endtask

   // Returns right after the edge that accepts the START write
   task automatic start_run(input bit md);
      apb_wr(0, {22'd0, md, 1'b1});
      apb_idle();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (golden_valid !== 1'b1 && n < NW + 100);
      if (golden_valid !== 1'b1) chk("valid_seen", 0, 1);
   endtask

   task automatic respond(input bit cat_v, input int delay, input bit ec);
      repeat (delay) begin @(posedge clk); #1; end
      dut_done = 1'b1; CAT = cat_v;
      @(posedge clk); #1;
      dut_done = 1'b0; CAT = 1'b0;
      chk("mismatch", mismatch, cat_v != ec);
      chk("no_timeout", timeout, 0);
      if (cat_v != ec) exp_err++;
      chk("err_cnt", error_count, exp_err);
      chk("busy_after", busy, 0);
   endtask

   task automatic run_and_check(input string tag, input bit md, input bit cat_v, input int delay);
      int n;
      longint s;
      bit ec;
      start_run(md);
      chk({tag, "_busy"}, busy, 1);
      wait_valid(n);
      chk({tag, "_lat"}, n, NW);
      s  = model_acc();
      ec = model_cat(s, md);
      chk({tag, "_acc"}, golden_acc, s);
      chk({tag, "_cat"}, golden_cat, ec);
      respond(cat_v, delay, ec);
   endtask

   initial begin
      int n, p0, h0, t0, m0, v0;
      rst = 1'b0; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
      CAT = 0; dut_done = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_acc", golden_acc, 0);
      chk("rst_errcnt", error_count, 0);
      chk("rst_proto", proto_err, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: pixels 10, weights +1
      fill(1, 1, 0, {3{8'd10}}, {3{8'd1}});
      chk("t1_no_hazard", n_haz, 0);
      chk("t1_no_proto", n_proto, 0);
      run_and_check("t1", 0, 1, 5);
      chk("t1_acc_const", golden_acc, 30720);

      // 2: weights 0, mode 0 with wrong CAT, then mode 1 with dut_done on the last legal cycle
      fill(0, 1, 0, '0, '0);
      run_and_check("t2a", 0, 1, 3);
      chk("t2a_errcnt_const", error_count, 1);
      t0 = n_to;
      run_and_check("t2b", 1, 1, TO);
      chk("t2b_cat_const", golden_cat, 1);
      chk("t2b_no_to", n_to - t0, 0);

      // 3: pixels 0xFF, weights -16
      fill(1, 1, 0, {3{8'hFF}}, {3{8'h10}});
      run_and_check("t3", 0, 0, 10);
      chk("t3_acc_const", golden_acc, -12533760);

      // 4/5: mid-CALC dut_done, mid-CALC START and pixel write, then timeout
      p0 = n_proto; h0 = n_haz; t0 = n_to;
      start_run(0);
      repeat (100) begin @(posedge clk); #1; end
      dut_done = 1'b1;
      @(posedge clk); #1;
      dut_done = 1'b0;
      apb_wr(0, 24'h1);
      apb_idle();
      apb_wr(1, m_pix[0]);
      apb_idle();
      wait_valid(n);
      chk("t4_lat", n, NW - 107);
      chk("t4_acc", golden_acc, model_acc());
      chk("t4_proto", n_proto - p0, 2);
      chk("t4_hazard", n_haz - h0, 1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (timeout !== 1'b1 && n < TO + 20);
      chk("t4_to_lat", n, TO + 1);
      exp_err++;
      chk("t4_errcnt", error_count, exp_err);
      chk("t4_idle", busy, 0);
      @(posedge clk); #1;
      chk("t4_to_count", n_to - t0, 1);

      p0 = n_proto;
      @(posedge clk); #1;
      PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 13'd5; PWDATA = 24'h1;
      apb_idle();
      @(posedge clk); #1;
      PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 13'd5; PWDATA = 24'h1;
      @(posedge clk); #1;
      PENABLE = 1; PWDATA = 24'h2;
      apb_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("t5_proto", n_proto - p0, 2);

      // 6: reset mid-CALC, then a clean rerun
      start_run(0);
      repeat (500) begin @(posedge clk); #1; end
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("t6_busy", busy, 0);
      chk("t6_acc", golden_acc, 0);
      chk("t6_cat", golden_cat, 0);
      chk("t6_valid", golden_valid, 0);
      chk("t6_errcnt", error_count, 0);
      chk("t6_pulses", {proto_err, write_hazard, mismatch, timeout}, 0);
      p0 = n_proto; h0 = n_haz; t0 = n_to; m0 = n_mm; v0 = n_valid;
      rst = 1'b1;
      exp_err = 0;
      repeat (5) begin @(posedge clk); #1; end
      chk("t6_exit_pulses", (n_proto - p0) + (n_haz - h0) + (n_to - t0) + (n_mm - m0) + (n_valid - v0), 0);
      run_and_check("t6", 0, 0, 4);

      // Random images
      for (int r = 0; r < 2; r++) begin
         fill(1, 1, 1, '0, '0);
         run_and_check("rnd", 1'($urandom), 1'($urandom), int'($urandom_range(0, TO)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
